// File: rtl/vj_pkg.sv
// rtl/vj_pkg.sv - shared widths and state encoding for the Viola-Jones feature evaluator
package vj_pkg;

  localparam int VJ_II_DATA_W = 32;
  localparam int VJ_WEIGHT_W  = 8;
  localparam int VJ_ACC_W     = 48;
  localparam int VJ_LEAF_W    = 16;
  localparam int VJ_X_W       = 10;
  localparam int VJ_Y_W       = 9;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACC,
    CMP,
    OUT
  } vj_state_t;

endpackage

// File: rtl/vj_feature_eval.sv
// rtl/vj_feature_eval.sv - sequences up to three rect sums through vj_rect_sum, weights them and picks a leaf
module vj_feature_eval
  import vj_pkg::*;
#(
  parameter int II_DATA_W = VJ_II_DATA_W,
  parameter int WEIGHT_W  = VJ_WEIGHT_W,
  parameter int ACC_W     = VJ_ACC_W,
  parameter int LEAF_W    = VJ_LEAF_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  feat_valid,
  output logic                  feat_ready,
  input  logic [VJ_X_W-1:0]     win_x,
  input  logic [VJ_Y_W-1:0]     win_y,
  input  logic [1:0]            num_rects,
  input  logic [3*VJ_X_W-1:0]   rect_x,
  input  logic [3*VJ_Y_W-1:0]   rect_y,
  input  logic [3*VJ_X_W-1:0]   rect_w,
  input  logic [3*VJ_Y_W-1:0]   rect_h,
  input  logic [3*WEIGHT_W-1:0] rect_wt,
  input  logic [ACC_W-1:0]      threshold,
  input  logic [LEAF_W-1:0]     left_val,
  input  logic [LEAF_W-1:0]     right_val,
  output logic                  rs_start,
  output logic [VJ_X_W-1:0]     rs_x,
  output logic [VJ_Y_W-1:0]     rs_y,
  output logic [VJ_X_W-1:0]     rs_w,
  output logic [VJ_Y_W-1:0]     rs_h,
  input  logic                  rs_busy,
  input  logic                  rs_done,
  input  logic [II_DATA_W:0]    rs_sum,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [LEAF_W-1:0]     res_val,
  output logic [ACC_W-1:0]      res_acc
);

  localparam int PROD_W = II_DATA_W + 1 + WEIGHT_W;

  vj_state_t                 state;
  logic [VJ_X_W-1:0]         win_x_q;
  logic [VJ_Y_W-1:0]         win_y_q;
  logic [1:0]                n_q;
  logic [1:0]                idx;
  logic [3*VJ_X_W-1:0]       rect_x_q;
  logic [3*VJ_Y_W-1:0]       rect_y_q;
  logic [3*VJ_X_W-1:0]       rect_w_q;
  logic [3*VJ_Y_W-1:0]       rect_h_q;
  logic [3*WEIGHT_W-1:0]     wt_q;
  logic signed [ACC_W-1:0]   thr_q;
  logic [LEAF_W-1:0]         left_q;
  logic [LEAF_W-1:0]         right_q;
  logic signed [II_DATA_W:0] sum_q;
  logic signed [ACC_W-1:0]   acc;

  logic [1:0]                idx_nx;
  logic signed [WEIGHT_W-1:0] wt_cur;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   prod_ext;

  always_comb begin
    idx_nx   = idx + 2'd1;
    wt_cur   = $signed(wt_q[idx*WEIGHT_W +: WEIGHT_W]);
    prod     = sum_q * wt_cur;
    prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  end

  assign feat_ready = (state == IDLE);
  // Start is qualified by busy in the same cycle so a busy engine never sees a pulse.
  assign rs_start   = (state == ISSUE) && !rs_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rs_x      <= '0;
      rs_y      <= '0;
      rs_w      <= '0;
      rs_h      <= '0;
      res_valid <= 1'b0;
      res_val   <= '0;
      res_acc   <= '0;
      acc       <= '0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: if (feat_valid) begin
          win_x_q  <= win_x;
          win_y_q  <= win_y;
          n_q      <= num_rects;
          rect_x_q <= rect_x;
          rect_y_q <= rect_y;
          rect_w_q <= rect_w;
          rect_h_q <= rect_h;
          wt_q     <= rect_wt;
          thr_q    <= $signed(threshold);
          left_q   <= left_val;
          right_q  <= right_val;
          acc      <= '0;
          idx      <= '0;
          if (num_rects != 2'd0) begin
            rs_x  <= win_x + rect_x[VJ_X_W-1:0];
            rs_y  <= win_y + rect_y[VJ_Y_W-1:0];
            rs_w  <= rect_w[VJ_X_W-1:0];
            rs_h  <= rect_h[VJ_Y_W-1:0];
            state <= ISSUE;
          end else begin
            state <= CMP;
          end
        end
        ISSUE: if (!rs_busy) state <= WAIT;
        WAIT: if (rs_done) begin
          sum_q <= $signed(rs_sum);
          state <= ACC;
        end
        ACC: begin
          acc <= acc + prod_ext;
          idx <= idx_nx;
          // Preload the next rect here so rs_* are already stable when ISSUE fires.
          if (idx_nx < n_q) begin
            rs_x  <= win_x_q + rect_x_q[idx_nx*VJ_X_W +: VJ_X_W];
            rs_y  <= win_y_q + rect_y_q[idx_nx*VJ_Y_W +: VJ_Y_W];
            rs_w  <= rect_w_q[idx_nx*VJ_X_W +: VJ_X_W];
            rs_h  <= rect_h_q[idx_nx*VJ_Y_W +: VJ_Y_W];
            state <= ISSUE;
          end else begin
            state <= CMP;
          end
        end
        CMP: begin
          res_val   <= (acc < thr_q) ? left_q : right_q;
          res_acc   <= acc;
          res_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: if (res_ready) begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vj_feature_eval.sv
// tb/tb_vj_feature_eval.sv - randomized and directed bench for vj_feature_eval with a scripted rect-sum model
module tb_vj_feature_eval;

  typedef struct {
    longint x;
    longint y;
    longint w;
    longint h;
  } rect_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        feat_valid = 1'b0;
  logic        feat_ready;
  logic [9:0]  win_x = '0;
  logic [8:0]  win_y = '0;
  logic [1:0]  num_rects = '0;
  logic [29:0] rect_x = '0;
  logic [26:0] rect_y = '0;
  logic [29:0] rect_w = '0;
  logic [26:0] rect_h = '0;
  logic [23:0] rect_wt = '0;
  logic [47:0] threshold = '0;
  logic [15:0] left_val = '0;
  logic [15:0] right_val = '0;
  logic        rs_start;
  logic [9:0]  rs_x;
  logic [8:0]  rs_y;
  logic [9:0]  rs_w;
  logic [8:0]  rs_h;
  logic        rs_busy = 1'b0;
  logic        rs_done = 1'b0;
  logic [32:0] rs_sum = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [15:0] res_val;
  logic [47:0] res_acc;

  vj_feature_eval dut (
    .clk(clk), .reset(reset), .feat_valid(feat_valid), .feat_ready(feat_ready),
    .win_x(win_x), .win_y(win_y), .num_rects(num_rects),
    .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
    .rect_wt(rect_wt), .threshold(threshold), .left_val(left_val), .right_val(right_val),
    .rs_start(rs_start), .rs_x(rs_x), .rs_y(rs_y), .rs_w(rs_w), .rs_h(rs_h),
    .rs_busy(rs_busy), .rs_done(rs_done), .rs_sum(rs_sum),
    .res_valid(res_valid), .res_ready(res_ready), .res_val(res_val), .res_acc(res_acc)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Descriptor as the model sees it.
  int     n;
  int     wx, wy;
  int     rx[3], ry[3], rw[3], rh[3];
  longint wt[3];
  longint thr, lv, rv;

  // Model expectations and bookkeeping shared with the compare process.
  rect_t  rect_q[$];
  longint sum_q[$];
  longint exp_acc, exp_val;
  int     exp_lat;
  int     lat_cfg = 1;
  bit     exp_idle = 1'b1;
  bit     exp_res_pending = 1'b0;
  bit     lat_checked;
  int     acc_cyc;
  int     feature_starts;
  longint last_acc, last_val, last_rs_x, last_rs_y;

  int     rs_cnt = 0;
  longint pend_sum;
  bit     live = 1'b0;
  rect_t  cur_r;

  always @(negedge clk) begin
    if (reset) begin
      exp_idle = 1'b1;
      exp_res_pending = 1'b0;
      rect_q.delete();
      live = 1'b0;
    end else begin
      chk("feat_ready", longint'(feat_ready), longint'(exp_idle));
      if (rs_start) begin
        if (rect_q.size() == 0) begin
          chk("spurious_rs_start", longint'(rs_start), longint'(0));
        end else begin
          cur_r = rect_q.pop_front();
          chk("rs_x", longint'(rs_x), cur_r.x);
          chk("rs_y", longint'(rs_y), cur_r.y);
          chk("rs_w", longint'(rs_w), cur_r.w);
          chk("rs_h", longint'(rs_h), cur_r.h);
          feature_starts++;
          last_rs_x = longint'(rs_x);
          last_rs_y = longint'(rs_y);
        end
      end
      if (res_valid) begin
        if (!exp_res_pending) begin
          chk("spurious_res_valid", longint'(res_valid), longint'(0));
        end else begin
          if (!lat_checked && exp_lat >= 0)
            chk("latency", longint'(cyc - acc_cyc), longint'(exp_lat));
          lat_checked = 1'b1;
          chk("res_acc", longint'($signed(res_acc)), exp_acc);
          chk("res_val", longint'($signed(res_val)), exp_val);
          if (res_ready) begin
            exp_res_pending = 1'b0;
            exp_idle = 1'b1;
            last_acc = longint'($signed(res_acc));
            last_val = longint'($signed(res_val));
          end
        end
      end
      if (exp_idle && feat_valid && feat_ready) begin
        exp_idle = 1'b0;
        exp_res_pending = 1'b1;
        acc_cyc = cyc;
        lat_checked = 1'b0;
        feature_starts = 0;
      end
    end

    // Rect-sum engine: done rises L cycles after the start cycle, counting through resets.
    rs_done = 1'b0;
    if (rs_cnt > 0) begin
      rs_cnt--;
      if (rs_cnt == 0) begin
        rs_done = 1'b1;
        rs_sum = pend_sum[32:0];
        if (live) begin
          chk("rs_x_stable", longint'(rs_x), cur_r.x);
          chk("rs_y_stable", longint'(rs_y), cur_r.y);
          chk("rs_w_stable", longint'(rs_w), cur_r.w);
          chk("rs_h_stable", longint'(rs_h), cur_r.h);
          live = 1'b0;
        end
      end
    end
    if (!reset && rs_start) begin
      rs_cnt = lat_cfg;
      pend_sum = (sum_q.size() > 0) ? sum_q.pop_front() : longint'(0);
      live = 1'b1;
    end
  end

  function automatic longint model_acc(input longint s[3]);
    longint a = 0;
    for (int i = 0; i < n; i++) a += s[i] * wt[i];
    return (a <<< 16) >>> 16;
  endfunction

  task automatic load_model(input int lat, input int busy_cyc, input longint s[3]);
    rect_t r;
    sum_q.delete();
    rect_q.delete();
    for (int i = 0; i < n; i++) begin
      sum_q.push_back(s[i]);
      r.x = longint'((wx + rx[i]) % 1024);
      r.y = longint'((wy + ry[i]) % 512);
      r.w = longint'(rw[i]);
      r.h = longint'(rh[i]);
      rect_q.push_back(r);
    end
    exp_acc = model_acc(s);
    exp_val = (exp_acc < thr) ? lv : rv;
    exp_lat = (busy_cyc == 0) ? 2 + n * (lat + 2) : -1;
    lat_cfg = lat;
    win_x = wx[9:0];
    win_y = wy[8:0];
    num_rects = n[1:0];
    rect_x = {rx[2][9:0], rx[1][9:0], rx[0][9:0]};
    rect_y = {ry[2][8:0], ry[1][8:0], ry[0][8:0]};
    rect_w = {rw[2][9:0], rw[1][9:0], rw[0][9:0]};
    rect_h = {rh[2][8:0], rh[1][8:0], rh[0][8:0]};
    rect_wt = {wt[2][7:0], wt[1][7:0], wt[0][7:0]};
    threshold = thr[47:0];
    left_val = lv[15:0];
    right_val = rv[15:0];
  endtask

  task automatic accept_feature(input int busy_cyc);
    feat_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (!exp_idle) break;
    end
    #1;
    feat_valid = 1'b0;
    win_x = 10'($urandom);
    win_y = 9'($urandom);
    num_rects = 2'($urandom);
    rect_x = 30'($urandom);
    rect_wt = 24'($urandom);
    threshold = {16'($urandom), 32'($urandom)};
    left_val = 16'($urandom);
    right_val = 16'($urandom);
    rs_busy = (busy_cyc > 0);
  endtask

  task automatic run_feature(input int lat, input int busy_cyc, input int ready_lo, input longint s[3]);
    load_model(lat, busy_cyc, s);
    res_ready = (ready_lo == 0);
    accept_feature(busy_cyc);
    if (busy_cyc > 0) begin
      repeat (busy_cyc) @(posedge clk);
      #1 rs_busy = 1'b0;
    end
    if (ready_lo > 0) begin
      for (int k = 0; k < 500; k++) begin
        @(negedge clk);
        if (res_valid) break;
      end
      repeat (ready_lo) @(posedge clk);
      #1 res_ready = 1'b1;
    end
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk);
      if (exp_idle) break;
    end
    chk("feature_complete", longint'(exp_idle), longint'(1));
    #1;
  endtask

  function automatic longint rand_sum();
    longint v = longint'($urandom);
    if ($urandom_range(1) == 1) v -= (longint'(1) <<< 32);
    return v;
  endfunction

  initial begin
    longint s[3];
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_res_valid", longint'(res_valid), longint'(0));
    chk("reset_res_acc", longint'(res_acc), longint'(0));
    chk("reset_res_val", longint'(res_val), longint'(0));
    chk("reset_rs_start", longint'(rs_start), longint'(0));
    chk("reset_rs_xy", longint'({rs_x, rs_y, rs_w, rs_h}), longint'(0));
    @(posedge clk); #1;

    // 2 rects, -1*1000 + 2*400 = -200 < -150 -> left leaf.
    n = 2; wx = 10; wy = 20; rx = '{1, 2, 0}; ry = '{3, 4, 0}; rw = '{5, 6, 1}; rh = '{7, 8, 1};
    wt = '{-1, 2, 0}; thr = -150; lv = 111; rv = -222;
    s = '{1000, 400, 0};
    run_feature(3, 0, 0, s);
    chk("t1_acc", last_acc, longint'(-200));
    chk("t1_val", last_val, longint'(111));
    chk("t1_starts", longint'(feature_starts), longint'(2));

    // 3 rects at window (100,50); third offset (4,3).
    n = 3; wx = 100; wy = 50; rx = '{0, 2, 4}; ry = '{0, 1, 3}; rw = '{8, 8, 8}; rh = '{4, 4, 4};
    wt = '{1, 2, 3}; thr = 0; lv = 5; rv = 6;
    s = '{10, 20, 30};
    run_feature(2, 0, 0, s);
    chk("t2_third_rs_x", last_rs_x, longint'(104));
    chk("t2_third_rs_y", last_rs_y, longint'(53));
    chk("t2_acc", last_acc, longint'(140));

    // No rects, threshold 0: acc 0 is not below 0 -> right leaf.
    n = 0; thr = 0; lv = 7; rv = 9;
    run_feature(1, 0, 0, s);
    chk("t3_acc", last_acc, longint'(0));
    chk("t3_val", last_val, longint'(9));
    chk("t3_starts", longint'(feature_starts), longint'(0));

    // Engine busy for 5 cycles, downstream stalls 4 cycles.
    n = 1; wx = 3; wy = 4; rx = '{1, 0, 0}; ry = '{1, 0, 0}; rw = '{2, 0, 0}; rh = '{2, 0, 0};
    wt = '{-5, 0, 0}; thr = 100; lv = -1; rv = 1;
    s = '{77, 0, 0};
    run_feature(2, 5, 4, s);
    chk("t4_starts", longint'(feature_starts), longint'(1));
    chk("t4_acc", last_acc, longint'(-385));

    // Reset while waiting on the engine; its late done must be ignored.
    n = 2; wx = 0; wy = 0; rx = '{0, 0, 0}; ry = '{0, 0, 0}; rw = '{1, 1, 1}; rh = '{1, 1, 1};
    wt = '{1, 1, 1}; thr = 0; lv = 1; rv = 2;
    s = '{5, 6, 0};
    load_model(8, 0, s);
    accept_feature(0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("t5_idle_after_abort", longint'(feat_ready), longint'(1));

    // Accumulator exactly equal to threshold -> right leaf.
    n = 1; wt = '{3, 0, 0}; thr = 150; lv = 40; rv = 41;
    s = '{50, 0, 0};
    run_feature(1, 0, 0, s);
    chk("t6_val", last_val, longint'(41));
    chk("t6_acc", last_acc, longint'(150));

    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(3);
      wx = $urandom_range(1023);
      wy = $urandom_range(511);
      for (int i = 0; i < 3; i++) begin
        rx[i] = $urandom_range(1023);
        ry[i] = $urandom_range(511);
        rw[i] = $urandom_range(1023);
        rh[i] = $urandom_range(511);
        wt[i] = longint'($urandom_range(255)) - 128;
        s[i] = rand_sum();
      end
      lv = longint'($urandom_range(65535)) - 32768;
      rv = longint'($urandom_range(65535)) - 32768;
      case ($urandom_range(2))
        0: thr = model_acc(s);
        1: thr = model_acc(s) + 1;
        default: thr = longint'($urandom) - (longint'(1) <<< 31);
      endcase
      run_feature($urandom_range(1, 5), $urandom_range(3), $urandom_range(3), s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vj_feature_eval.md
VJ_FEATURE_EVAL -- requirements
Module: vj_feature_eval

Interface
REQ-001 SHALL have parameters: II_DATA_W, default 32, integral-image word width; WEIGHT_W, default 8, signed rect weight width; ACC_W, default 48, signed accumulator width; LEAF_W, default 16, signed leaf value width.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- feat_valid  in  1  feature descriptor valid
- feat_ready  out  1  descriptor accepted when valid&&ready
- win_x  in  10  window origin x
- win_y  in  9  window origin y
- num_rects  in  2  rectangles to evaluate (0..3)
- rect_x/rect_y/rect_w/rect_h  in  3x10/3x9/3x10/3x9 packed  per-rect offset/size, rect 0 in LSBs
- rect_wt  in  3xWEIGHT_W packed  signed per-rect weight
- threshold  in  ACC_W  signed node threshold
- left_val/right_val  in  LEAF_W  signed leaf values
- rs_start  out  1  one-cycle start pulse to vj_rect_sum
- rs_x/rs_y/rs_w/rs_h  out  10/9/10/9  rect to vj_rect_sum
- rs_busy/rs_done  in  1/1  vj_rect_sum status
- rs_sum  in  II_DATA_W+1  signed rect sum
- res_valid  out  1  result valid, held until res_ready
- res_ready  in  1  downstream accept
- res_val  out  LEAF_W  selected leaf value
- res_acc  out  ACC_W  final weighted sum

Function
REQ-003 SHALL use states IDLE, ISSUE, WAIT, ACC, CMP, OUT.
REQ-004 feat_ready SHALL be 1 only in IDLE; on a handshake, all descriptor inputs SHALL be latched, acc cleared, rect index cleared; next state ISSUE if num_rects>0, else CMP.
REQ-005 ISSUE: if rs_busy=0, SHALL pulse rs_start for exactly one cycle with rs_x=win_x+rect_x[i] (mod 1024), rs_y=win_y+rect_y[i] (mod 512), rs_w=rect_w[i], rs_h=rect_h[i], then go to WAIT; if rs_busy=1, SHALL stay in ISSUE with rs_start=0.
REQ-006 rs_x/rs_y/rs_w/rs_h SHALL stay stable from the rs_start cycle until rs_done is sampled.
REQ-007 WAIT: SHALL capture rs_sum on the cycle rs_done=1, then go to ACC; no timeout.
REQ-008 ACC: acc <= acc + sext(rs_sum * rect_wt[i]) (signed, full product width II_DATA_W+1+WEIGHT_W, sign-extended to ACC_W, accumulator wraps on overflow); index increments; next is ISSUE if index+1<num_rects, else CMP.
REQ-009 CMP: res_val <= (acc < threshold, signed) ? left_val : right_val; res_acc <= acc; go to OUT.
REQ-010 OUT: res_valid=1 with res_val/res_acc stable until res_ready=1; on handshake SHALL return to IDLE; feat_ready rises the following cycle.
REQ-011 rs_done outside WAIT SHALL be ignored.
REQ-012 Latency, rs_busy=0, rect-sum latency L cycles from start to done: feat handshake to res_valid = 1 + n*(L+2) + 1 cycles for n=num_rects (n=0: 2 cycles).
REQ-013 Descriptor inputs SHALL be ignored outside the IDLE handshake.

Reset
REQ-014 While reset=1 at a clk edge: state=IDLE, rs_start=0, rs_x/rs_y/rs_w/rs_h=0, res_valid=0, res_val=0, res_acc=0, acc=0, index=0; feat_ready=1 after reset deasserts.
REQ-015 Reset mid-operation SHALL abandon the feature with no res_valid; a later rs_done from the aborted request SHALL be ignored per REQ-011.

Structure
REQ-016 State encoding and default widths (II_DATA_W, WEIGHT_W, ACC_W, LEAF_W) SHALL live in shared package vj_pkg.
REQ-017 No sub-module; vj_rect_sum is instantiated by the parent and connected via the rs_* ports.

Verification
REQ-018 Bench SHALL model vj_rect_sum with configurable latency L and scripted sums, and SHALL cover:
- 2 rects, sums 1000/400, weights -1/+2, threshold -150 -> res_acc=-200, res_val=left_val, exactly 2 rs_start pulses.
- 3 rects, win (100,50), rect2 offset (4,3) -> third rs_x=104, rs_y=53; acc equals sum of 3 weighted products.
- num_rects=0, threshold 0 -> no rs_start, res_acc=0, res_val=right_val, res_valid 2 cycles after accept.
- rs_busy held 5 cycles at ISSUE -> rs_start delayed until busy=0, still a single pulse; res_ready low 4 cycles -> res_* stable, feat_ready=0 throughout.
- reset asserted in WAIT, then stray rs_done -> no res_valid; next feature gives correct result.
- acc exactly equal to threshold -> right_val selected.
